// File: rtl/prbs31_pkg.sv
// Shared types and constants for the PRBS31 loopback test controller and its checker.
package prbs31_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [30:0] PRBS31_SEED_DEFAULT = 31'h7FFF_FFFF;
  localparam int unsigned PRBS31_LEN          = 31;
  localparam int unsigned TAP_A               = 30;
  localparam int unsigned TAP_B               = 27;

  // x^31 + x^28 + 1: the next bit is the XOR of the bits 31 and 28 positions back.
  function automatic logic prbs31_predict(input logic [30:0] r);
    return r[TAP_A] ^ r[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_test_ctrl_if.sv
// Generator control and loopback receive signals between the test controller and the PRBS path.
interface prbs31_test_ctrl_if;
  logic        gen_load;
  logic [30:0] gen_seed;
  logic        gen_en;
  logic        rx_bit;
  logic        rx_valid;

  modport master (
    output gen_load,
    output gen_seed,
    output gen_en,
    input  rx_bit,
    input  rx_valid
  );

  modport slave (
    input  gen_load,
    input  gen_seed,
    input  gen_en,
    output rx_bit,
    output rx_valid
  );
endinterface

// File: rtl/prbs31_chk.sv
// Self-synchronising PRBS31 checker: shift register, lock counter and saturating error counter.
module prbs31_chk
  import prbs31_pkg::*;
#(
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             lock_clr,
  input  logic             rx_bit,
  output logic             lock,
  output logic [ERR_W-1:0] err_count
);

  logic [30:0]      r;
  logic [4:0]       lock_cnt;
  logic [ERR_W-1:0] err_q;
  logic             bit_err;

  assign lock      = (lock_cnt == 5'(PRBS31_LEN));
  assign err_count = err_q;
  // Prediction uses the register before this bit is shifted in.
  assign bit_err   = shift_en && lock && (rx_bit != prbs31_predict(r));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r        <= '0;
      lock_cnt <= '0;
      err_q    <= '0;
    end else begin
      if (shift_en) begin
        r <= {r[29:0], rx_bit};
      end
      if (lock_clr) begin
        lock_cnt <= '0;
      end else if (shift_en && !lock) begin
        lock_cnt <= lock_cnt + 5'd1;
      end
      if (bit_err && (err_q != '1)) begin
        err_q <= err_q + ERR_W'(1);
      end
    end
  end

endmodule

// File: rtl/prbs31_test_ctrl.sv
// PRBS31 loopback test controller: run sequencing FSM and bit counter around the checker.
module prbs31_test_ctrl
  import prbs31_pkg::*;
#(
  parameter logic [30:0] SEED  = PRBS31_SEED_DEFAULT,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned ERR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LEN_W-1:0]          run_len,
  prbs31_test_ctrl_if.master        gen_if,
  output logic                      busy,
  output logic                      done,
  output logic                      lock,
  output logic [ERR_W-1:0]          err_count
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q;
  logic             accept;
  logic             aborting;
  logic             gen_load_c;
  logic             gen_en_c;
  logic             busy_c;
  logic             done_c;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    aborting   = 1'b0;
    gen_load_c = 1'b0;
    gen_en_c   = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        done_c = (state_q == S_DONE);
        if (start) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy_c     = 1'b1;
        gen_load_c = 1'b1;
        aborting   = abort;
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        busy_c   = 1'b1;
        aborting = abort;
        gen_en_c = !abort;
        // Abort outranks the final-bit transition to DONE.
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= run_len;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

  assign gen_if.gen_load = gen_load_c;
  assign gen_if.gen_seed = SEED;
  assign gen_if.gen_en   = gen_en_c;
  assign busy            = busy_c;
  assign done            = done_c;

  prbs31_chk #(
    .ERR_W(ERR_W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift_en ((state_q == S_RUN) && gen_if.rx_valid && !abort),
    .lock_clr (aborting),
    .rx_bit   (gen_if.rx_bit),
    .lock     (lock),
    .err_count(err_count)
  );

endmodule

// File: tb/tb_prbs31_test_ctrl.sv
// Scoreboard bench for prbs31_test_ctrl: 16-bit and 4-bit error counter instances driven in lockstep.
module tb_prbs31_test_ctrl;

  localparam logic [30:0] SEED_EXP = 31'h7FFF_FFFF;
  localparam int MAXLEN = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] run_len = '0;
  logic        busy16, done16, lock16;
  logic [15:0] err16;
  logic        busy4, done4, lock4;
  logic [3:0]  err4;

  prbs31_test_ctrl_if if16();
  prbs31_test_ctrl_if if4();

  prbs31_test_ctrl dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .run_len(run_len),
    .gen_if(if16), .busy(busy16), .done(done16), .lock(lock16), .err_count(err16)
  );

  prbs31_test_ctrl #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .run_len(run_len),
    .gen_if(if4), .busy(busy4), .done(done4), .lock(lock4), .err_count(err4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;      // 0 done, 1 abort, 2 reset
    int err16;
    int err4;
    bit lock;
    int gen;
    int cyc;
    int lock_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   prbs [MAXLEN];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_rx(input bit v, input bit b);
    if16.rx_valid = v; if4.rx_valid = v;
    if16.rx_bit   = b; if4.rx_bit   = b;
  endtask

  task automatic noise();
    set_rx(1'($urandom % 2), 1'($urandom % 2));
  endtask

  // ---------------- monitor ----------------
  logic rst_q = 1'b0;
  bit   in_run = 0;
  bit   hold = 0;
  int   cyc, gen_cnt, loads, lock_cyc;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      if (in_run) begin
        if (sb.size() == 0) chk("scoreboard_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("end_kind_reset", e.kind, 2);
          chk("gen_en_cycles", gen_cnt, e.gen);
        end
        in_run = 0;
      end
      chk("rst_gen_load", {if16.gen_load, if4.gen_load}, 0);
      chk("rst_gen_en", {if16.gen_en, if4.gen_en}, 0);
      chk("rst_busy", {busy16, busy4}, 0);
      chk("rst_done", {done16, done4}, 0);
      chk("rst_lock", {lock16, lock4}, 0);
      chk("rst_err16", err16, 0);
      chk("rst_err4", err4, 0);
      chk("rst_gen_seed", if16.gen_seed, SEED_EXP);
      cur = '{kind: 2, err16: 0, err4: 0, lock: 0, gen: 0, cyc: 0, lock_cyc: -1};
      hold = 1;
    end else begin
      if (!in_run && if16.gen_load) begin
        in_run = 1; cyc = 0; gen_cnt = 0; loads = 1; lock_cyc = -1;
      end else if (in_run) begin
        cyc++;
        if (if16.gen_load) loads++;
      end
      if (in_run) begin
        if (if16.gen_en) gen_cnt++;
        if (lock16 && lock_cyc < 0) lock_cyc = cyc;
        if (!busy16) begin
          if (sb.size() == 0) chk("scoreboard_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("end_done16", done16, e.kind == 0);
            chk("end_done4", done4, e.kind == 0);
            chk("end_err16", err16, e.err16);
            chk("end_err4", err4, e.err4);
            chk("end_lock16", lock16, e.lock);
            chk("end_lock4", lock4, e.lock);
            chk("gen_en_cycles", gen_cnt, e.gen);
            chk("end_cycle", cyc, e.cyc);
            chk("lock_cycle", lock_cyc, e.lock_cyc);
            chk("gen_load_pulses", loads, 1);
            chk("end_gen_en", if16.gen_en, 0);
            chk("gen_seed", if16.gen_seed, SEED_EXP);
            cur = e;
          end
          hold = 1;
          in_run = 0;
        end
      end else if (hold) begin
        chk("hold_err16", err16, cur.err16);
        chk("hold_err4", err4, cur.err4);
        chk("hold_lock", {lock16, lock4}, {cur.lock, cur.lock});
        chk("hold_busy_gen_en", {busy16, if16.gen_en, busy4, if4.gen_en}, 0);
      end
    end
  end

  // ---------------- stimulus + reference model ----------------
  // abort_at: -2 none, -1 during LOAD, >=0 RUN cycle index; rst_at: -1 none, >=0 RUN cycle index.
  task automatic do_run(input int len, input int mode, input int abort_at, input int rst_at);
    bit   vld [MAXLEN];
    bit   bv  [MAXLEN];
    bit   rq[$];
    exp_t e;
    int   stop, nerr, j31;

    stop = len; e.kind = 0;
    if (abort_at == -1) begin stop = 0; e.kind = 1; end
    else if (abort_at >= 0 && abort_at < len) begin stop = abort_at; e.kind = 1; end
    else if (rst_at >= 0 && rst_at < len) begin stop = rst_at; e.kind = 2; end

    for (int j = 0; j < len; j++) begin
      case (mode)
        0: begin vld[j] = 1; bv[j] = prbs[j]; end
        1: begin vld[j] = 1; bv[j] = prbs[j] ^ ((j == 200) || (j == 500)); end
        2: begin vld[j] = 1; bv[j] = !prbs[j]; end
        default: begin vld[j] = ($urandom % 4) != 0; bv[j] = 1'($urandom % 2); end
      endcase
    end

    j31 = -1;
    for (int j = 0; j < stop; j++) begin
      if (vld[j]) begin
        rq.push_back(bv[j]);
        if (rq.size() == 31) j31 = j;
      end
    end
    nerr = 0;
    for (int k = 31; k < rq.size(); k++)
      if (rq[k] != (rq[k-31] ^ rq[k-28])) nerr++;

    e.err16    = (nerr > 65535) ? 65535 : nerr;
    e.err4     = (nerr > 15) ? 15 : nerr;
    e.lock     = (e.kind == 0) && (rq.size() >= 31);
    e.lock_cyc = (j31 >= 0) ? j31 + 2 : -1;
    e.gen      = (e.kind == 0) ? len : (e.kind == 2) ? rst_at + 1 : (abort_at < 0 ? 0 : abort_at);
    e.cyc      = (e.kind == 0) ? len + 1 : abort_at + 2;
    sb.push_back(e);

    // Start with a random abort alongside: abort is meaningless in IDLE/DONE.
    start = 1; run_len = 16'(len); abort = 1'($urandom % 2); noise();
    @(posedge clk); #1;
    start = 0; abort = (abort_at == -1); noise();
    @(posedge clk); #1;
    if (abort_at != -1) begin
      for (int j = 0; j < len; j++) begin
        abort = (j == abort_at);
        rst   = (j == rst_at);
        start = ($urandom % 4) == 0;
        set_rx(vld[j], bv[j]);
        @(posedge clk); #1;
        if (j == abort_at || j == rst_at) break;
      end
    end
    abort = 0; rst = 0; start = 0;
    repeat (3) begin
      noise(); abort = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    abort = 0; set_rx(0, 0);
  endtask

  initial begin
    bit s [MAXLEN + 31];
    int len, mode, sel, ab, rs;
    for (int i = 0; i < 31; i++) s[i] = 1;
    for (int i = 31; i < MAXLEN + 31; i++) s[i] = s[i-31] ^ s[i-28];
    for (int i = 0; i < MAXLEN; i++) prbs[i] = s[i+31];

    set_rx(0, 0);
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    do_run(100,  0, -2, -1);
    do_run(1000, 0, -2, -1);
    do_run(1000, 1, -2, -1);
    do_run(0,    0, -2, -1);
    do_run(100,  0, 50, -1);
    do_run(100,  0, -2, 60);
    do_run(200,  2, -2, -1);
    do_run(20,   0, -1, -1);

    for (int r = 0; r < 20; r++) begin
      len  = $urandom_range(0, 300);
      mode = $urandom_range(0, 3);
      sel  = $urandom % 6;
      ab   = -2; rs = -1;
      if (sel == 0) ab = int'($urandom_range(0, len)) - 1;
      else if (sel == 1 && len > 0) rs = $urandom_range(0, len - 1);
      do_run(len, mode, ab, rs);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
